axis_connect_pipe_left_shift: RTL and testbench

AXIS_CONNECT_PIPE_LEFT_SHIFT -- requirements
Module: axis_connect_pipe_left_shift

---
 rtl/axis_connect_pipe_left_shift_pkg.sv | 8 +
 rtl/axis_connect_pipe_left_shift_inf.sv | 29 ++
 rtl/axis_connect_pipe_left_shift_shift.sv | 114 +++++++++++
 rtl/axis_connect_pipe_left_shift.sv | 41 ++++
 tb/tb_axis_connect_pipe_left_shift.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_connect_pipe_left_shift_pkg.sv
// Shared system package: elaboration-time helpers used across the stream blocks.
package SystemPkg;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/axis_connect_pipe_left_shift_inf.sv
// AXI-stream and generic valid/ready data interfaces used by the shift pipe.
interface axi_stream_inf #(
  parameter int DSIZE = 8
) (
  input logic aclk,
  input logic aresetn
);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [DSIZE-1:0] tdata;

  modport master (input aclk, aresetn, tready, output tvalid, tdata, tlast);
  modport slaver (input aclk, aresetn, tvalid, tdata, tlast, output tready);
endinterface

interface data_inf_c #(
  parameter int DSIZE = 8
) (
  input logic clock,
  input logic rst_n
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (input clock, rst_n, ready, output valid, data);
  modport slaver (input clock, rst_n, valid, data, output ready);
endinterface

// File: rtl/axis_connect_pipe_left_shift_shift.sv
// Packet-wide left shift: each beat takes the top bits of the previous beat,
// optionally followed by one tail beat holding the carry-out of the last beat.
module data_c_pipe_inf_left_shift
  import SystemPkg::*;
#(
  parameter int SHIFT_BITS  = 1,
  parameter int EXTEND_TAIL = 1
) (
  input  logic      ex_in,
  output logic      ex_out,
  data_inf_c.slaver indata,
  data_inf_c.master outdata
);
  localparam int DSIZE = $bits(indata.data);

  if (!in_range(SHIFT_BITS, 1, DSIZE - 1)) begin : g_shift_check
    $error("SHIFT_BITS %0d outside 1..%0d", SHIFT_BITS, DSIZE - 1);
  end

  typedef enum logic {
    STREAM,
    TAIL
  } state_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       rst_sync;
  logic             run;
  state_t           state, state_nx;
  logic [DSIZE-1:0] carry, carry_nx;
  logic [DSIZE-1:0] odata, odata_nx;
  logic             ovalid, ovalid_nx;
  logic             olast, olast_nx;
  logic [DSIZE-1:0] carry_bits;
  logic [DSIZE-1:0] in_shift;
  logic             in_ready;
  logic             accept;
  logic             out_free;

  assign clk   = indata.clock;
  assign rst_n = indata.rst_n;

  // Reset asserts immediately but input acceptance resumes only on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign carry_bits = carry >> (DSIZE - SHIFT_BITS);
  assign in_shift   = (indata.data << SHIFT_BITS) | carry_bits;
  assign out_free   = !ovalid || outdata.ready;
  assign in_ready   = run && (state == STREAM) && out_free;
  assign accept     = indata.valid && in_ready;

  assign indata.ready  = in_ready;
  assign outdata.valid = ovalid;
  assign outdata.data  = odata;
  assign ex_out        = olast;

  always_comb begin
    state_nx  = state;
    carry_nx  = carry;
    odata_nx  = odata;
    ovalid_nx = ovalid;
    olast_nx  = olast;
    if (ovalid && outdata.ready) ovalid_nx = 1'b0;
    case (state)
      STREAM: begin
        if (accept) begin
          ovalid_nx = 1'b1;
          odata_nx  = in_shift;
          olast_nx  = 1'b0;
          carry_nx  = indata.data;
          if (ex_in) begin
            if (EXTEND_TAIL != 0) begin
              state_nx = TAIL;
            end else begin
              olast_nx = 1'b1;
              carry_nx = '0;
            end
          end
        end
      end
      TAIL: begin
        if (out_free) begin
          ovalid_nx = 1'b1;
          odata_nx  = carry_bits;
          olast_nx  = 1'b1;
          carry_nx  = '0;
          state_nx  = STREAM;
        end
      end
      default: state_nx = STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STREAM;
      carry  <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
      olast  <= 1'b0;
    end else begin
      state  <= state_nx;
      carry  <= carry_nx;
      odata  <= odata_nx;
      ovalid <= ovalid_nx;
      olast  <= olast_nx;
    end
  end

endmodule

// File: rtl/axis_connect_pipe_left_shift.sv
// AXI-stream wrapper: maps the stream interfaces onto the generic shift pipe.
module axis_connect_pipe_left_shift
  import SystemPkg::*;
#(
  parameter int SHIFT_BITS  = 1,
  parameter int EXTEND_TAIL = 1
) (
  axi_stream_inf.slaver axis_in,
  axi_stream_inf.master axis_out
);
  localparam int DSIZE = $bits(axis_in.tdata);

  if ($bits(axis_out.tdata) != DSIZE) begin : g_dsize_check
    $error("axis_in DSIZE %0d != axis_out DSIZE %0d", DSIZE, $bits(axis_out.tdata));
  end

  logic out_last;

  data_inf_c #(.DSIZE(DSIZE)) in_inf  (.clock(axis_in.aclk), .rst_n(axis_in.aresetn));
  data_inf_c #(.DSIZE(DSIZE)) out_inf (.clock(axis_in.aclk), .rst_n(axis_in.aresetn));

  assign in_inf.valid   = axis_in.tvalid;
  assign in_inf.data    = axis_in.tdata;
  assign axis_in.tready = in_inf.ready;

  assign axis_out.tvalid = out_inf.valid;
  assign axis_out.tdata  = out_inf.data;
  assign axis_out.tlast  = out_last;
  assign out_inf.ready   = axis_out.tready;

  data_c_pipe_inf_left_shift #(
    .SHIFT_BITS (SHIFT_BITS),
    .EXTEND_TAIL(EXTEND_TAIL)
  ) u_shift (
    .ex_in  (axis_in.tlast),
    .ex_out (out_last),
    .indata (in_inf.slaver),
    .outdata(out_inf.master)
  );

endmodule

// File: tb/tb_axis_connect_pipe_left_shift.sv
// Bench for axis_connect_pipe_left_shift: three configurations, directed and random packets.
module tb_axis_connect_pipe_left_shift;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: SHIFT=1 TAIL=1, index 1: SHIFT=1 TAIL=0, index 2: SHIFT=4 TAIL=1
  logic [2:0] in_valid = '0;
  logic [2:0] in_last  = '0;
  logic [7:0] in_data [3];
  logic [2:0] out_ready = '1;
  wire  [2:0] in_ready;
  wire  [2:0] out_valid;
  wire  [2:0] out_last;
  wire  [7:0] out_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SB = (g == 2) ? 4 : 1;
    localparam int ET = (g == 1) ? 0 : 1;
    axi_stream_inf #(.DSIZE(8)) ain  (.aclk(clk), .aresetn(rst_n));
    axi_stream_inf #(.DSIZE(8)) aout (.aclk(clk), .aresetn(rst_n));
    assign ain.tvalid   = in_valid[g];
    assign ain.tdata    = in_data[g];
    assign ain.tlast    = in_last[g];
    assign in_ready[g]  = ain.tready;
    assign out_valid[g] = aout.tvalid;
    assign out_data[g]  = aout.tdata;
    assign out_last[g]  = aout.tlast;
    assign aout.tready  = out_ready[g];
    axis_connect_pipe_left_shift #(.SHIFT_BITS(SB), .EXTEND_TAIL(ET)) dut (
      .axis_in (ain),
      .axis_out(aout)
    );
  end

  int tests = 0;
  int fails = 0;
  int cur = 0;
  bit gaps = 1'b0;
  int rmode [3] = '{0, 0, 0};
  logic [8:0] stim_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] held_d [3];
  bit   [2:0] held_v = '0;

  function automatic int cfg_sb(input int i);
    return (i == 2) ? 4 : 1;
  endfunction
  function automatic int cfg_et(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: whole packet as one little-endian bit vector, shifted left.
  function automatic void model(input int sb, input int et);
    logic [1023:0] vec = '0;
    int n = 0;
    exp_q.delete();
    foreach (stim_q[i]) begin
      vec[8*n +: 8] = stim_q[i][7:0];
      n++;
      if (stim_q[i][8]) begin
        vec = vec << sb;
        for (int k = 0; k < n + et; k++)
          exp_q.push_back({(k == n - 1 + et) ? 1'b1 : 1'b0, vec[8*k +: 8]});
        vec = '0;
        n = 0;
      end
    end
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      out_ready[i] = (rmode[i] == 0) ? 1'b1 :
                     (rmode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        held_v[i] = 1'b0;
      end else begin
        if (held_v[i])
          chk($sformatf("stall_hold%0d", i), {7'd0, out_valid[i], out_last[i], out_data[i]},
              {7'd0, 1'b1, held_d[i]});
        held_v[i] = out_valid[i] && !out_ready[i];
        held_d[i] = {out_last[i], out_data[i]};
        if (out_valid[i] && out_ready[i] && i == cur)
          got_q.push_back({out_last[i], out_data[i]});
      end
    end
  end

  task automatic drive(input int idx);
    int w;
    foreach (stim_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid[idx] = 1'b0;
      end
      @(negedge clk);
      in_valid[idx] = 1'b1;
      in_data[idx]  = stim_q[i][7:0];
      in_last[idx]  = stim_q[i][8];
      #1;
      w = 0;
      while (!in_ready[idx] && w < 200) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (!in_ready[idx]) begin
        tests++;
        fails++;
        $error("FAIL in_ready_wait%0d: observed 0 expected 1", idx);
      end
    end
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int w = 0;
    while (got_q.size() < exp_q.size() && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    #3;
    chk({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), {7'd0, got_q[i]}, {7'd0, exp_q[i]});
  endtask

  task automatic start(input int idx);
    cur = idx;
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tvalid%0d", i), {15'd0, out_valid[i]}, 16'd0);
      chk($sformatf("rst_tdata%0d", i), {8'd0, out_data[i]}, 16'd0);
      chk($sformatf("rst_tlast%0d", i), {15'd0, out_last[i]}, 16'd0);
      chk($sformatf("rst_tready%0d", i), {15'd0, in_ready[i]}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    start(0);
    stim_q = '{9'h081, 9'h101};
    exp_q  = '{9'h002, 9'h003, 9'h100};
    drive(0);
    check_out("two_beat_tail");

    start(1);
    stim_q = '{9'h081, 9'h101};
    exp_q  = '{9'h002, 9'h103};
    drive(1);
    check_out("two_beat_notail");

    start(2);
    stim_q = '{9'h1AB};
    exp_q  = '{9'h0B0, 9'h10A};
    drive(2);
    #1;
    chk("tail_tready", {15'd0, in_ready[2]}, 16'd0);
    check_out("shift4_single");

    start(0);
    stim_q = '{9'h1FF, 9'h101};
    exp_q  = '{9'h0FE, 9'h101, 9'h002, 9'h100};
    drive(0);
    check_out("back_to_back");

    start(1);
    stim_q = '{9'h1FF, 9'h101, 9'h1C3};
    exp_q  = '{9'h1FE, 9'h102, 9'h186};
    drive(1);
    check_out("single_notail");

    gaps = 1'b1;
    for (int idx = 0; idx < 3; idx++) begin
      int npk;
      npk = (idx == 0) ? 1000 : 200;
      start(idx);
      rmode[idx] = 1;
      stim_q.delete();
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++)
          stim_q.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
      end
      model(cfg_sb(idx), cfg_et(idx));
      drive(idx);
      check_out($sformatf("random%0d", idx));
      rmode[idx] = 0;
    end
    gaps = 1'b0;

    start(0);
    rmode[0] = 2;
    stim_q = '{9'h181};
    drive(0);
    #1;
    chk("tail_hold_tready", {15'd0, in_ready[0]}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {15'd0, out_valid[0]}, 16'd0);
    chk("mid_rst_tready", {15'd0, in_ready[0]}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rmode[0] = 0;
    start(0);
    stim_q = '{9'h140};
    exp_q  = '{9'h080, 9'h100};
    drive(0);
    check_out("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
